gpioa_controller: RTL and testbench

Memory-mapped GPIO port A peripheral that implements the peripheral side of the processor's peripheral bus. It decodes bus reads and writes into a small register file. It drives the port A output and direction lines, and synchronises the port A input pins. It latches per-pin edge events into sticky cause bits and raises a level interrupt towards the core.

---
 rtl/gpioa_pkg.sv | 31 +++
 rtl/gpioa_sync_edge.sv | 34 +++
 rtl/gpioa_controller.sv | 123 ++++++++++++
 tb/tb_gpioa_controller.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/gpioa_pkg.sv
// Shared definitions for the GPIO port A peripheral: register map, index type
// and the per-pin edge-select encoding.
package gpioa_pkg;

   typedef logic [2:0] reg_idx_t;

   typedef enum logic {
      EDGE_RISE = 1'b0,
      EDGE_FALL = 1'b1
   } edge_sel_e;

   localparam logic [4:0] DDR_OFS   = 5'h00;
   localparam logic [4:0] OUT_OFS   = 5'h04;
   localparam logic [4:0] IN_OFS    = 5'h08;
   localparam logic [4:0] MASK_OFS  = 5'h0C;
   localparam logic [4:0] CAUSE_OFS = 5'h10;
   localparam logic [4:0] EDGE_OFS  = 5'h14;
   localparam logic [4:0] SET_OFS   = 5'h18;
   localparam logic [4:0] CLR_OFS   = 5'h1C;

   // Registers are word-spaced, so the decode only looks at byte offset bits [4:2].
   localparam reg_idx_t DDR_IDX   = DDR_OFS[4:2];
   localparam reg_idx_t OUT_IDX   = OUT_OFS[4:2];
   localparam reg_idx_t IN_IDX    = IN_OFS[4:2];
   localparam reg_idx_t MASK_IDX  = MASK_OFS[4:2];
   localparam reg_idx_t CAUSE_IDX = CAUSE_OFS[4:2];
   localparam reg_idx_t EDGE_IDX  = EDGE_OFS[4:2];
   localparam reg_idx_t SET_IDX   = SET_OFS[4:2];
   localparam reg_idx_t CLR_IDX   = CLR_OFS[4:2];

endpackage

// File: rtl/gpioa_sync_edge.sv
// Two-flop pin synchroniser plus a history flop, producing the settled pin value
// and per-pin rising/falling event strobes.
module gpioa_sync_edge #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] pin_i,
   output logic [WIDTH-1:0] sync_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o
);

   logic [WIDTH-1:0] s1_q;
   logic [WIDTH-1:0] s2_q;
   logic [WIDTH-1:0] s3_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         s1_q <= pin_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign sync_o = s2_q;
   assign rise_o = s2_q & ~s3_q;
   assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/gpioa_controller.sv
// GPIO port A bus slave: register file, address decode, sticky edge causes and
// a registered level interrupt towards the core.
module gpioa_controller
   import gpioa_pkg::*;
#(
   parameter int                          MEMORY_BUS_WIDTH = 32,
   parameter logic [MEMORY_BUS_WIDTH-1:0] BASE_ADDR        = 32'hE100_0000
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [MEMORY_BUS_WIDTH-1:0] addr_in,
   input  logic [MEMORY_BUS_WIDTH-1:0] data_in,
   output logic [MEMORY_BUS_WIDTH-1:0] data_out,
   input  logic                        sel_in,
   input  logic                        wr_in,
   output logic                        irq,
   input  logic [7:0]                  gpioa_in,
   output logic [7:0]                  gpioa_out,
   output logic [7:0]                  gpioa_ddr
);

   localparam int W = MEMORY_BUS_WIDTH;

   logic [7:0]   ddr_q, ddr_d;
   logic [7:0]   out_q, out_d;
   logic [7:0]   mask_q, mask_d;
   logic [7:0]   cause_q, cause_d;
   logic [7:0]   edgeSel_q, edgeSel_d;
   logic [W-1:0] dataOut_q, dataOut_d;
   logic         irq_q, irq_d;

   logic [7:0]   pinSync, pinRise, pinFall, pinEvent;
   logic [7:0]   causeClr, readByte, wrByte;
   logic         busHit, wrHit, rdHit;
   reg_idx_t     regIdx;
   logic         unusedBusBits;

   gpioa_sync_edge #(.WIDTH(8)) uSyncEdge (
      .clock  (clock),
      .reset  (reset),
      .pin_i  (gpioa_in),
      .sync_o (pinSync),
      .rise_o (pinRise),
      .fall_o (pinFall)
   );

   assign busHit        = sel_in && (addr_in[W-1:5] == BASE_ADDR[W-1:5]);
   assign wrHit         = busHit && wr_in;
   assign rdHit         = busHit && !wr_in;
   assign regIdx        = addr_in[4:2];
   assign wrByte        = data_in[7:0];
   assign unusedBusBits = ^{addr_in[1:0], data_in};

   always_comb begin
      pinEvent = '0;
      for (int i = 0; i < 8; i++) begin
         pinEvent[i] = (edge_sel_e'(edgeSel_q[i]) == EDGE_FALL) ? pinFall[i] : pinRise[i];
      end
   end

   always_comb begin
      ddr_d     = ddr_q;
      out_d     = out_q;
      mask_d    = mask_q;
      edgeSel_d = edgeSel_q;
      causeClr  = '0;
      if (wrHit) begin
         case (regIdx)
            DDR_IDX:   ddr_d     = wrByte;
            OUT_IDX:   out_d     = wrByte;
            MASK_IDX:  mask_d    = wrByte;
            CAUSE_IDX: causeClr  = wrByte;
            EDGE_IDX:  edgeSel_d = wrByte;
            SET_IDX:   out_d     = out_q | wrByte;
            CLR_IDX:   out_d     = out_q & ~wrByte;
            default:   ;
         endcase
      end
      // A fresh event outranks a same-cycle clear so no edge is ever lost.
      cause_d = (cause_q & ~causeClr) | pinEvent;
   end

   always_comb begin
      readByte = '0;
      case (regIdx)
         DDR_IDX:   readByte = ddr_q;
         OUT_IDX:   readByte = out_q;
         IN_IDX:    readByte = pinSync;
         MASK_IDX:  readByte = mask_q;
         CAUSE_IDX: readByte = cause_q;
         EDGE_IDX:  readByte = edgeSel_q;
         default:   readByte = '0;
      endcase
      dataOut_d = rdHit ? W'(readByte) : '0;
      irq_d     = |(cause_q & mask_q);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ddr_q     <= '0;
         out_q     <= '0;
         mask_q    <= '0;
         cause_q   <= '0;
         edgeSel_q <= '0;
         dataOut_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         ddr_q     <= ddr_d;
         out_q     <= out_d;
         mask_q    <= mask_d;
         cause_q   <= cause_d;
         edgeSel_q <= edgeSel_d;
         dataOut_q <= dataOut_d;
         irq_q     <= irq_d;
      end
   end

   assign data_out  = dataOut_q;
   assign irq       = irq_q;
   assign gpioa_out = out_q;
   assign gpioa_ddr = ddr_q;

endmodule

// File: tb/tb_gpioa_controller.sv
// Bench for gpioa_controller: directed register/edge/irq scenarios followed by
// random bus and pin traffic, all checked each cycle against a history-based model.
module tb_gpioa_controller;

   localparam logic [31:0] BASE = 32'hE100_0000;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] addr_in;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        sel_in;
   logic        wr_in;
   logic        irq;
   logic [7:0]  gpioa_in;
   logic [7:0]  gpioa_out;
   logic [7:0]  gpioa_ddr;

   int testsRun    = 0;
   int testsFailed = 0;

   // Model: register contents by word index, plus pin samples from the last three edges.
   logic [7:0]  mReg [8];
   logic [7:0]  pinHist [3];
   logic [31:0] mDataOut;
   logic        mIrq;

   gpioa_controller #(
      .MEMORY_BUS_WIDTH (32),
      .BASE_ADDR        (BASE)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .addr_in   (addr_in),
      .data_in   (data_in),
      .data_out  (data_out),
      .sel_in    (sel_in),
      .wr_in     (wr_in),
      .irq       (irq),
      .gpioa_in  (gpioa_in),
      .gpioa_out (gpioa_out),
      .gpioa_ddr (gpioa_ddr)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic modelStep();
      logic [7:0] rise, fall, evt, clr, wd;
      logic       hit;
      int         idx;
      if (reset) begin
         for (int i = 0; i < 8; i++) mReg[i] = 8'h00;
         for (int i = 0; i < 3; i++) pinHist[i] = 8'h00;
         mDataOut = 32'h0;
         mIrq     = 1'b0;
      end else begin
         hit = sel_in && (addr_in[31:5] == BASE[31:5]);
         idx = int'(addr_in[4:2]);
         wd  = data_in[7:0];
         clr = 8'h00;
         mDataOut = 32'h0;
         if (hit && !wr_in) begin
            if (idx == 2)      mDataOut = {24'h0, pinHist[1]};
            else if (idx < 6)  mDataOut = {24'h0, mReg[idx]};
         end
         mIrq = |(mReg[4] & mReg[3]);
         rise = pinHist[1] & ~pinHist[2];
         fall = ~pinHist[1] & pinHist[2];
         evt  = (mReg[5] & fall) | (~mReg[5] & rise);
         if (hit && wr_in) begin
            case (idx)
               0, 1, 3, 5: mReg[idx] = wd;
               4:          clr = wd;
               6:          mReg[1] = mReg[1] | wd;
               7:          mReg[1] = mReg[1] & ~wd;
               default:    ;
            endcase
         end
         mReg[4]    = (mReg[4] & ~clr) | evt;
         pinHist[2] = pinHist[1];
         pinHist[1] = pinHist[0];
         pinHist[0] = gpioa_in;
      end
   endtask

   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                input logic sel, input logic wr, input logic rst);
      addr_in = addr;
      data_in = data;
      sel_in  = sel;
      wr_in   = wr;
      reset   = rst;
      @(posedge clock);
      modelStep();
      #1;
      checkOutput("data_out", data_out, mDataOut);
      checkOutput("irq", {31'h0, irq}, {31'h0, mIrq});
      checkOutput("gpioa_out", {24'h0, gpioa_out}, {24'h0, mReg[1]});
      checkOutput("gpioa_ddr", {24'h0, gpioa_ddr}, {24'h0, mReg[0]});
   endtask

   task automatic busWrite(input logic [4:0] ofs, input logic [7:0] value);
      applyStimulus(BASE | {27'h0, ofs}, {24'hA5A5A5, value}, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic busRead(input logic [4:0] ofs);
      applyStimulus(BASE | {27'h0, ofs}, $urandom, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mReg[i] = 8'h00;
      for (int i = 0; i < 3; i++) pinHist[i] = 8'h00;
      gpioa_in = 8'h00;
      applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      for (int r = 0; r < 8; r++) begin
         busRead(5'(r * 4));
         checkOutput("reset_read", data_out, 32'h0);
      end
      checkOutput("reset_irq", {31'h0, irq}, 32'h0);

      busWrite(5'h00, 8'hF0);
      checkOutput("ddr_write", {24'h0, gpioa_ddr}, 32'hF0);
      busWrite(5'h04, 8'h5A);
      checkOutput("out_write", {24'h0, gpioa_out}, 32'h5A);
      busRead(5'h04);
      checkOutput("out_read", data_out, 32'h5A);
      busWrite(5'h18, 8'h01);
      checkOutput("out_set", {24'h0, gpioa_out}, 32'h5B);
      busWrite(5'h1C, 8'h50);
      checkOutput("out_clr", {24'h0, gpioa_out}, 32'h0B);
      busRead(5'h18);
      checkOutput("set_reads_zero", data_out, 32'h0);

      busWrite(5'h0C, 8'h08);
      busWrite(5'h14, 8'h00);
      gpioa_in = 8'h08;
      idle(3);
      checkOutput("irq_before_e3", {31'h0, irq}, 32'h0);
      idle(1);
      checkOutput("irq_at_e3", {31'h0, irq}, 32'h1);
      busRead(5'h10);
      checkOutput("cause_rise", data_out, 32'h08);
      busRead(5'h08);
      checkOutput("in_read", data_out, 32'h08);
      busWrite(5'h10, 8'h08);
      idle(1);
      checkOutput("irq_cleared", {31'h0, irq}, 32'h0);

      busWrite(5'h14, 8'h02);
      gpioa_in = 8'h0A;
      idle(4);
      busRead(5'h10);
      checkOutput("no_cause_on_rise", data_out, 32'h0);
      gpioa_in = 8'h08;
      idle(3);
      busRead(5'h10);
      checkOutput("cause_fall", data_out, 32'h02);
      checkOutput("irq_masked_off", {31'h0, irq}, 32'h0);
      busWrite(5'h0C, 8'h02);
      idle(1);
      checkOutput("irq_mask_on", {31'h0, irq}, 32'h1);

      gpioa_in = 8'h0C;
      idle(2);
      busWrite(5'h10, 8'h04);
      busRead(5'h10);
      checkOutput("collision", data_out, 32'h06);
      busWrite(5'h10, 8'h04);
      busRead(5'h10);
      checkOutput("cause_clr2", data_out, 32'h02);

      applyStimulus(BASE + 32'h24, 32'hFF, 1'b1, 1'b1, 1'b0);
      checkOutput("miss_write", {24'h0, gpioa_out}, 32'h0B);
      applyStimulus(BASE + 32'h4, 32'hFF, 1'b0, 1'b1, 1'b0);
      checkOutput("nosel_write", {24'h0, gpioa_out}, 32'h0B);
      applyStimulus(BASE + 32'h20, 32'h0, 1'b1, 1'b0, 1'b0);
      checkOutput("miss_read", data_out, 32'h0);
      applyStimulus(BASE, 32'hFF, 1'b1, 1'b1, 1'b1);
      checkOutput("reset_vs_write", {24'h0, gpioa_ddr}, 32'h0);
      idle(3);
      busRead(5'h10);
      checkOutput("held_pin_cause", data_out, 32'h0C);
      checkOutput("held_pin_irq", {31'h0, irq}, 32'h0);

      for (int n = 0; n < 2000; n++) begin
         logic [31:0] a;
         if ($urandom_range(3) != 0) a = BASE | ($urandom & 32'h1F);
         else                        a = $urandom;
         if ($urandom_range(3) == 0) gpioa_in = 8'($urandom);
         applyStimulus(a, $urandom, 1'($urandom), 1'($urandom), $urandom_range(199) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
